// File: rtl/bsg_axil_dmi_bridge.sv
// AXI4-Lite slave to RISC-V DMI bridge. It handles one transaction at a time, retries when
// the DMI reports busy, and returns SLVERR on a response timeout. A response that arrives
// after a timeout is drained and discarded.
module bsg_axil_dmi_bridge #(
    parameter int s_axil_data_width_p = 32,
    parameter int s_axil_addr_width_p = 32,
    parameter int dmi_addr_width_p    = 7,
    parameter int retry_p             = 4,
    parameter int timeout_p           = 1024
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [s_axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                       s_axil_awprot_i,
    input  logic                             s_axil_awvalid_i,
    output logic                             s_axil_awready_o,
    input  logic [s_axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [s_axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                             s_axil_wvalid_i,
    output logic                             s_axil_wready_o,
    output logic [1:0]                       s_axil_bresp_o,
    output logic                             s_axil_bvalid_o,
    input  logic                             s_axil_bready_i,
    input  logic [s_axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                       s_axil_arprot_i,
    input  logic                             s_axil_arvalid_i,
    output logic                             s_axil_arready_o,
    output logic [s_axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                       s_axil_rresp_o,
    output logic                             s_axil_rvalid_o,
    input  logic                             s_axil_rready_i,
    output logic                             dmi_req_v_o,
    output logic [dmi_addr_width_p-1:0]      dmi_req_addr_o,
    output logic [s_axil_data_width_p-1:0]   dmi_req_data_o,
    output logic [1:0]                       dmi_req_op_o,
    input  logic                             dmi_req_ready_i,
    input  logic                             dmi_resp_v_i,
    input  logic [s_axil_data_width_p-1:0]   dmi_resp_data_i,
    input  logic [1:0]                       dmi_resp_op_i,
    output logic                             dmi_resp_ready_o
);

    localparam int L  = $clog2(s_axil_data_width_p/8);
    localparam int TW = $clog2(timeout_p+1);
    localparam int RW = (retry_p > 0) ? $clog2(retry_p+1) : 1;
    localparam logic [TW-1:0] TIMEOUT   = TW'(timeout_p);
    localparam logic [RW-1:0] RETRY_MAX = RW'(retry_p);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_BRESP = 3'd3,
        S_RRESP = 3'd4
    } state_e;

    state_e                         r_state;
    state_e                         w_state_next;
    state_e                         w_done_state;
    logic                           r_is_read;
    logic                           r_stale;
    logic [TW-1:0]                  r_timer;
    logic [RW-1:0]                  r_retry_cnt;
    logic [dmi_addr_width_p-1:0]    r_addr;
    logic [s_axil_data_width_p-1:0] r_wdata;
    logic [1:0]                     r_op;
    logic [1:0]                     r_resp;
    logic [s_axil_data_width_p-1:0] r_rdata;

    logic                           w_idle_open;
    logic                           w_accept_rd;
    logic                           w_accept_wr;
    logic                           w_strb_full;
    logic                           w_req_hs;
    logic                           w_axi_done;
    logic [TW-1:0]                  w_timer_inc;
    logic                           w_set_resp;
    logic [1:0]                     w_resp_val;
    logic [s_axil_data_width_p-1:0] w_rdata_val;
    logic                           w_retry;
    logic                           w_set_stale;
    logic                           w_unused;

    assign w_unused    = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_awaddr_i, s_axil_araddr_i};
    // Gating with reset_i keeps the AXI readies low while reset is applied.
    assign w_idle_open = (r_state == S_IDLE) && !r_stale && !reset_i;
    assign w_accept_rd = w_idle_open && s_axil_arvalid_i;
    assign w_accept_wr = w_idle_open && !s_axil_arvalid_i && s_axil_awvalid_i && s_axil_wvalid_i;
    assign w_strb_full = &s_axil_wstrb_i;
    assign w_req_hs    = (r_state == S_REQ) && dmi_req_ready_i;
    assign w_axi_done  = ((r_state == S_BRESP) && s_axil_bready_i) ||
                         ((r_state == S_RRESP) && s_axil_rready_i);
    assign w_timer_inc = (r_timer == TIMEOUT) ? r_timer : r_timer + TW'(1);

    assign s_axil_arready_o = w_accept_rd;
    assign s_axil_awready_o = w_accept_wr;
    assign s_axil_wready_o  = w_accept_wr;
    assign s_axil_bvalid_o  = (r_state == S_BRESP);
    assign s_axil_rvalid_o  = (r_state == S_RRESP);
    assign s_axil_bresp_o   = r_resp;
    assign s_axil_rresp_o   = r_resp;
    assign s_axil_rdata_o   = r_rdata;
    assign dmi_req_v_o      = (r_state == S_REQ);
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_data_o   = r_wdata;
    assign dmi_req_op_o     = r_op;
    assign dmi_resp_ready_o = (r_state == S_WAIT) || r_stale;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and completion status; a response beats the timeout in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_done_state = r_is_read ? S_RRESP : S_BRESP;
        w_set_resp   = 1'b0;
        w_resp_val   = RESP_OKAY;
        w_rdata_val  = '0;
        w_retry      = 1'b0;
        w_set_stale  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_rd) begin
                    w_state_next = S_REQ;
                end else if (w_accept_wr && w_strb_full) begin
                    w_state_next = S_REQ;
                end else if (w_accept_wr) begin
                    w_state_next = S_BRESP;
                    w_set_resp   = 1'b1;
                    w_resp_val   = RESP_SLVERR;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (dmi_req_ready_i) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (dmi_resp_v_i) begin
                    case (dmi_resp_op_i)
                        2'd0: begin
                            w_state_next = w_done_state;
                            w_set_resp   = 1'b1;
                            w_resp_val   = RESP_OKAY;
                            w_rdata_val  = r_is_read ? dmi_resp_data_i : '0;
                        end
                        2'd3: begin
                            if (r_retry_cnt < RETRY_MAX) begin
                                w_state_next = S_REQ;
                                w_retry      = 1'b1;
                            end else begin
                                w_state_next = w_done_state;
                                w_set_resp   = 1'b1;
                                w_resp_val   = RESP_SLVERR;
                            end
                        end
                        default: begin
                            w_state_next = w_done_state;
                            w_set_resp   = 1'b1;
                            w_resp_val   = RESP_SLVERR;
                        end
                    endcase
                end else if (w_timer_inc == TIMEOUT) begin
                    w_state_next = w_done_state;
                    w_set_resp   = 1'b1;
                    w_resp_val   = RESP_SLVERR;
                    w_set_stale  = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_BRESP: begin
                if (s_axil_bready_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_BRESP;
                end
            end
            S_RRESP: begin
                if (s_axil_rready_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RRESP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request capture, timer, retry count, stale tracking and AXI response registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= 2'd0;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_stale     <= 1'b0;
            r_resp      <= 2'b00;
            r_rdata     <= '0;
        end else begin
            if (w_accept_rd) begin
                r_is_read <= 1'b1;
                r_addr    <= s_axil_araddr_i[L+dmi_addr_width_p-1:L];
                r_wdata   <= '0;
                r_op      <= 2'd1;
            end else if (w_accept_wr) begin
                r_is_read <= 1'b0;
                r_addr    <= s_axil_awaddr_i[L+dmi_addr_width_p-1:L];
                r_wdata   <= s_axil_wdata_i;
                r_op      <= 2'd2;
            end
            if (w_req_hs) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= w_timer_inc;
            end
            if (w_retry) begin
                r_retry_cnt <= r_retry_cnt + RW'(1);
            end else if (w_axi_done) begin
                r_retry_cnt <= '0;
            end
            if (w_set_stale) begin
                r_stale <= 1'b1;
            end else if (r_stale && dmi_resp_v_i) begin
                r_stale <= 1'b0;
            end
            if (w_set_resp) begin
                r_resp  <= w_resp_val;
                r_rdata <= w_rdata_val;
            end
        end
    end

endmodule

// File: tb/tb_bsg_axil_dmi_bridge.sv
// Scoreboard bench for bsg_axil_dmi_bridge: directed AXI transactions, a scripted DMI responder,
// and monitors that compare DMI requests and AXI responses against queued expectations.
module tb_bsg_axil_dmi_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DAW = 7;

    logic clk_i = 1'b0;
    logic reset_i;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic req_v, req_ready, resp_v, resp_ready;
    logic [DAW-1:0] req_addr;
    logic [DW-1:0] req_data, resp_data;
    logic [1:0] req_op, resp_op;

    bsg_axil_dmi_bridge #(
        .s_axil_data_width_p(DW), .s_axil_addr_width_p(AW), .dmi_addr_width_p(DAW),
        .retry_p(4), .timeout_p(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .dmi_req_v_o(req_v), .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data),
        .dmi_req_op_o(req_op), .dmi_req_ready_i(req_ready),
        .dmi_resp_v_i(resp_v), .dmi_resp_data_i(resp_data), .dmi_resp_op_i(resp_op),
        .dmi_resp_ready_o(resp_ready)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [DAW-1:0] addr; logic [1:0] op; logic [DW-1:0] data; } dmi_t;
    typedef struct packed { logic [1:0] resp; logic [DW-1:0] data; } rd_t;
    typedef struct packed { logic v; logic [1:0] op; logic [DW-1:0] data; } rsp_t;

    dmi_t dmi_q[$];
    rd_t  rd_q[$];
    logic [1:0] wr_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {awready, wready, arready, bvalid, rvalid, req_v, resp_ready}, 0);
        check({tag, "_axi_data"}, {bresp, rresp, rdata}, 0);
        check({tag, "_dmi_data"}, {req_addr, req_data, req_op}, 0);
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // DMI request monitor
    initial begin : dmi_mon
        dmi_t e;
        forever begin
            @(negedge clk_i);
            if (req_v && req_ready) begin
                n_req++;
                if (dmi_q.size() == 0) begin
                    check("dmi_unexpected_req", 1, 0);
                end else begin
                    e = dmi_q.pop_front();
                    check("dmi_addr", req_addr, e.addr);
                    check("dmi_op", req_op, e.op);
                    check("dmi_data", req_data, e.data);
                end
            end
        end
    end

    // AXI response monitor
    initial begin : axi_mon
        rd_t r;
        logic [1:0] b;
        forever begin
            @(negedge clk_i);
            if (rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    check("rresp", rresp, r.resp);
                    check("rdata", rdata, r.data);
                end
            end
            if (bvalid && bready) begin
                if (wr_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    b = wr_q.pop_front();
                    check("bresp", bresp, b);
                end
            end
        end
    end

    // Scripted DMI responder: one script entry per request handshake
    initial begin : responder
        rsp_t e;
        forever begin
            @(negedge clk_i);
            if (req_v && req_ready && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                @(posedge clk_i); #1;
                if (e.v) begin
                    resp_v = 1'b1; resp_op = e.op; resp_data = e.data;
                    @(posedge clk_i); #1;
                    resp_v = 1'b0; resp_op = 2'd0; resp_data = '0;
                end
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] addr, input int hold, output int lat);
        int acc, k;
        logic [DW-1:0] d0;
        arvalid = 1'b1; araddr = addr;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!arready && k < 50);
        check("ar_accept", arready, 1);
        if (awvalid) check("rd_over_wr", {awready, wready}, 0);
        acc = cyc;
        @(posedge clk_i); #1 arvalid = 1'b0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!rvalid && k < 200);
        check("rvalid_seen", rvalid, 1);
        lat = cyc - acc;
        d0 = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, d0);
            if (awvalid) check("aw_blocked", awready, 0);
        end
        @(posedge clk_i); #1 rready = 1'b1;
        @(posedge clk_i); #1 rready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s, output int waited, output int lat);
        int acc, k;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = d; wstrb = s;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!awready && k < 50);
        check("aw_accept", {awready, wready}, 2'b11);
        waited = k - 1;
        acc = cyc;
        @(posedge clk_i); #1 awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!bvalid && k < 200);
        check("bvalid_seen", bvalid, 1);
        lat = cyc - acc;
        @(posedge clk_i); #1 bready = 1'b1;
        @(posedge clk_i); #1 bready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, waited, req0, k;
        reset_i = 1'b1;
        awaddr = '0; awprot = 3'd0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        req_ready = 1'b1; resp_v = 1'b0; resp_data = '0; resp_op = 2'd0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i); #1 reset_i = 1'b0;

        // Basic read
        rsp_q.push_back('{1'b1, 2'd0, 32'hDEADBEEF});
        dmi_q.push_back('{7'h11, 2'd1, 32'h0});
        rd_q.push_back('{2'b00, 32'hDEADBEEF});
        do_read(32'h44, 0, lat);
        check("read_latency", lat, 3);

        // Full-strobe write
        rsp_q.push_back('{1'b1, 2'd0, 32'h0});
        dmi_q.push_back('{7'h10, 2'd2, 32'h1});
        wr_q.push_back(2'b00);
        do_write(32'h40, 32'h1, 4'hF, waited, lat);
        check("write_latency", lat, 3);

        // Partial strobe: no DMI traffic, immediate SLVERR
        req0 = n_req;
        wr_q.push_back(2'b10);
        do_write(32'h40, 32'h1, 4'h3, waited, lat);
        check("partial_strb_latency", lat, 1);
        check("partial_strb_no_req", n_req - req0, 0);

        // Busy twice, then ok
        req0 = n_req;
        rsp_q.push_back('{1'b1, 2'd3, 32'h0});
        rsp_q.push_back('{1'b1, 2'd3, 32'h0});
        rsp_q.push_back('{1'b1, 2'd0, 32'h0});
        for (int i = 0; i < 3; i++) dmi_q.push_back('{7'h10, 2'd2, 32'h5});
        wr_q.push_back(2'b00);
        do_write(32'h40, 32'h5, 4'hF, waited, lat);
        check("busy2_reqs", n_req - req0, 3);
        check("busy2_latency", lat, 7);

        // Busy on every try: retries exhausted
        req0 = n_req;
        for (int i = 0; i < 5; i++) begin
            rsp_q.push_back('{1'b1, 2'd3, 32'h0});
            dmi_q.push_back('{7'h20, 2'd2, 32'hA5});
        end
        wr_q.push_back(2'b10);
        do_write(32'h80, 32'hA5, 4'hF, waited, lat);
        check("busy5_reqs", n_req - req0, 5);
        check("busy5_latency", lat, 11);

        // Timeout, then stale blocking and late-response drain
        rsp_q.push_back('{1'b0, 2'd0, 32'h0});
        dmi_q.push_back('{7'h12, 2'd1, 32'h0});
        rd_q.push_back('{2'b10, 32'h0});
        do_read(32'h48, 0, lat);
        check("timeout_latency", lat, 10);
        arvalid = 1'b1; araddr = 32'h4C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stale_blocks_ar", arready, 0);
        end
        check("stale_resp_ready", resp_ready, 1);
        @(posedge clk_i); #1 resp_v = 1'b1; resp_op = 2'd0; resp_data = 32'hBADBAD00;
        @(negedge clk_i);
        check("late_drain_blocked", arready, 0);
        @(posedge clk_i); #1 resp_v = 1'b0; resp_data = '0;
        rsp_q.push_back('{1'b1, 2'd0, 32'h12345678});
        dmi_q.push_back('{7'h13, 2'd1, 32'h0});
        rd_q.push_back('{2'b00, 32'h12345678});
        do_read(32'h4C, 0, lat);
        check("after_drain_latency", lat, 3);

        // Simultaneous read and write, with read backpressure
        rsp_q.push_back('{1'b1, 2'd0, 32'hCAFEF00D});
        rsp_q.push_back('{1'b1, 2'd0, 32'h0});
        dmi_q.push_back('{7'h14, 2'd1, 32'h0});
        dmi_q.push_back('{7'h15, 2'd2, 32'h77});
        rd_q.push_back('{2'b00, 32'hCAFEF00D});
        wr_q.push_back(2'b00);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h54; wdata = 32'h77; wstrb = 4'hF;
        do_read(32'h50, 5, lat);
        do_write(32'h54, 32'h77, 4'hF, waited, lat);
        check("write_after_read_wait", waited, 0);

        // Reset asserted in WAIT
        rsp_q.push_back('{1'b0, 2'd0, 32'h0});
        dmi_q.push_back('{7'h16, 2'd1, 32'h0});
        arvalid = 1'b1; araddr = 32'h58;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!arready && k < 50);
        check("rst_ar_accept", arready, 1);
        @(posedge clk_i); #1 arvalid = 1'b0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!resp_ready && k < 50);
        check("rst_in_wait", resp_ready, 1);
        #2 reset_i = 1'b1;
        #1 check_all_zero("midreset");
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        rsp_q.push_back('{1'b1, 2'd0, 32'h0BADF00D});
        dmi_q.push_back('{7'h17, 2'd1, 32'h0});
        rd_q.push_back('{2'b00, 32'h0BADF00D});
        do_read(32'h5C, 0, lat);
        check("post_reset_latency", lat, 3);

        repeat (5) @(negedge clk_i);
        check("dmi_q_empty", dmi_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
